wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have a single clock and a single reset: the clock is `clk` and the reset is `rst_n`, asynchronous and active-low.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  MEM-stage result offered.
- in_ready  output  1  stage accepts an offer this cycle.
- in_rd  input  5  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_wb_sel  input  2  data source: 00 = ALU, 01 = LOAD, 10 = PC+4, 11 = ALU.
- in_alu_result  input  32  ALU result.
- in_pc_plus4  input  32  link value.
- in_load_funct3  input  3  load type.
- in_addr_low  input  2  load byte offset.
- mem_rdata  input  32  data-memory read word.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- flush  input  1  abort an outstanding load.
- reg_write_addr  output  5  register-file write address.
- reg_write_data  output  32  register-file write data.
- reg_write_enable  output  1  register-file write strobe.
- retire_count  output  32  committed-instruction counter.

Function
REQ-003 SHALL implement the FSM states IDLE, WAIT_MEM and COMMIT.
REQ-004 SHALL drive in_ready=1 in IDLE and COMMIT, and in_ready=0 in WAIT_MEM.
REQ-005 SHALL accept a transaction on a rising edge when in_valid=1 and in_ready=1, capturing in_rd, in_reg_write, in_wb_sel, in_alu_result, in_pc_plus4, in_load_funct3 and in_addr_low.
REQ-006 SHALL transition to WAIT_MEM on accept when in_wb_sel=01, and to COMMIT on accept for any other in_wb_sel.
REQ-007 SHALL transition from COMMIT to IDLE when there is no accept.
REQ-008 SHALL, in WAIT_MEM, capture mem_rdata and transition to COMMIT on the edge where mem_rvalid=1.
REQ-009 SHALL ignore mem_rvalid in IDLE and COMMIT.
REQ-010 SHALL, in WAIT_MEM, transition to IDLE on the edge where flush=1, even if mem_rvalid=1 on that edge; no commit SHALL result.
REQ-011 SHALL ignore flush in IDLE and COMMIT.
REQ-012 SHALL have registered outputs reg_write_enable, reg_write_addr and reg_write_data, valid during the COMMIT cycle.
REQ-013 SHALL drive reg_write_enable=1 in COMMIT only when the captured reg_write=1 and captured rd!=0, and reg_write_enable=0 otherwise.
REQ-014 SHALL hold reg_write_addr and reg_write_data at their last values outside COMMIT.
REQ-015 SHALL give non-load latency as: accept at edge k, then write strobe high for exactly the cycle after edge k.
REQ-016 SHALL give load latency as: mem_rvalid sampled at edge j, then strobe high for the cycle after edge j; the minimum accept-to-strobe latency is 2 cycles.
REQ-017 SHALL sustain back-to-back non-load accepts, one commit per cycle, with the strobe continuous.
REQ-018 SHALL select write data per captured wb_sel: 00 or 11 = alu_result; 10 = pc_plus4; 01 = the extended load value.
REQ-019 SHALL extract load data by funct3 as follows:
- 000 LB: byte mem_rdata[8*addr_low+7 : 8*addr_low], sign-extended.
- 100 LBU: same byte, zero-extended.
- 001 LH: halfword at addr_low[1], sign-extended.
- 101 LHU: same halfword, zero-extended.
- 010 LW: full word.
- Any other funct3: 32'h0.
REQ-020 SHALL ignore addr_low[0] for halfword loads; addr_low SHALL be ignored for LW.
REQ-021 SHALL increment retire_count by 1 on every COMMIT cycle, including reg_write=0 or rd=0, and wrap 32'hFFFFFFFF to 0.

Reset
REQ-022 SHALL, while rst_n=0, immediately force state=IDLE, reg_write_enable=0, reg_write_addr=0, reg_write_data=0, retire_count=0 and all captured fields 0.
REQ-023 SHALL, on reset assertion mid-WAIT_MEM or mid-COMMIT, drop the pending transaction with no write.
REQ-024 SHALL ignore mem_rvalid arriving after reset release until a new load is accepted.
REQ-025 SHALL drive in_ready=1 from the first cycle after reset release.

Verification
REQ-026 SHALL be verified with these directed scenarios:
- ALU op: accept rd=5, wb_sel=00, alu=32'h1234 -> next cycle enable=1, addr=5, data=32'h1234; retire_count=1.
- LB: accept rd=7, wb_sel=01, funct3=000, addr_low=2; two cycles later mem_rvalid=1 with mem_rdata=32'h0080_0000 -> enable=1, addr=7, data=32'hFFFF_FF80; in_ready=0 while waiting.
- LHU: funct3=101, addr_low=2, mem_rdata=32'hBEEF_0000 -> data=32'h0000_BEEF.
- Flush: load accepted, flush=1 together with mem_rvalid=1 -> no strobe, state IDLE, retire_count unchanged.
- rd=0 or reg_write=0 with wb_sel=10 -> enable stays 0, retire_count still increments.
- Back-to-back: three ALU ops on consecutive cycles -> strobe high for three consecutive cycles with matching addr/data; rst_n pulsed low mid-load -> no write, outputs 0, retire_count 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU/link results immediately and load results once the
// data-memory read word arrives, with load extraction and a retired-instruction count.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_load_funct3,
  input  logic [1:0]  in_addr_low,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        flush,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_data,
  output logic        reg_write_enable,
  output logic [31:0] retire_count
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t            state;
  logic [REG_AW-1:0] cap_rd;
  logic              cap_reg_write;
  logic [1:0]        cap_wb_sel;
  logic [XLEN-1:0]   cap_alu_result;
  logic [XLEN-1:0]   cap_pc_plus4;
  logic [2:0]        cap_funct3;
  logic [1:0]        cap_addr_low;

  logic accept_c;
  assign accept_c = in_valid & in_ready;

  // Extract and extend the addressed byte/halfword from a read word.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return XLEN'(0);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_data(input logic [1:0] sel,
                                              input logic [XLEN-1:0] alu,
                                              input logic [XLEN-1:0] pc4,
                                              input logic [XLEN-1:0] ld);
    case (sel)
      SEL_LOAD: return ld;
      SEL_PC4:  return pc4;
      default:  return alu;
    endcase
  endfunction

  // Outputs are computed on the edge entering COMMIT so they are valid during that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      in_ready         <= 1'b1;
      reg_write_enable <= 1'b0;
      reg_write_addr   <= '0;
      reg_write_data   <= '0;
      retire_count     <= '0;
      cap_rd           <= '0;
      cap_reg_write    <= 1'b0;
      cap_wb_sel       <= '0;
      cap_alu_result   <= '0;
      cap_pc_plus4     <= '0;
      cap_funct3       <= '0;
      cap_addr_low     <= '0;
    end else begin
      reg_write_enable <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (accept_c) begin
            cap_rd         <= in_rd;
            cap_reg_write  <= in_reg_write;
            cap_wb_sel     <= in_wb_sel;
            cap_alu_result <= in_alu_result;
            cap_pc_plus4   <= in_pc_plus4;
            cap_funct3     <= in_load_funct3;
            cap_addr_low   <= in_addr_low;
            if (in_wb_sel == SEL_LOAD) begin
              state    <= WAIT_MEM;
              in_ready <= 1'b0;
            end else begin
              state            <= COMMIT;
              in_ready         <= 1'b1;
              reg_write_enable <= in_reg_write && (in_rd != '0);
              reg_write_addr   <= in_rd;
              reg_write_data   <= wb_data(in_wb_sel, in_alu_result, in_pc_plus4, XLEN'(0));
              retire_count     <= retire_count + XLEN'(1);
            end
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        WAIT_MEM: begin
          // Flush wins over a same-edge read response.
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else if (mem_rvalid) begin
            state            <= COMMIT;
            in_ready         <= 1'b1;
            reg_write_enable <= cap_reg_write && (cap_rd != '0);
            reg_write_addr   <= cap_rd;
            reg_write_data   <= wb_data(cap_wb_sel, cap_alu_result, cap_pc_plus4,
                                        load_extend(cap_funct3, cap_addr_low, mem_rdata));
            retire_count     <= retire_count + XLEN'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register writes are queued when stimulus is
// driven and popped whenever the write strobe is seen.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_addr_low;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        flush;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        reg_write_enable;
  logic [31:0] retire_count;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_load_funct3(in_load_funct3), .in_addr_low(in_addr_low),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; any strobe seen must match the oldest queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (reg_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(reg_write_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", 32'(reg_write_addr), 32'(e.addr));
        chk("sb_data", reg_write_data, e.data);
      end
    end
  endtask

  task automatic offer(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [1:0] al);
    in_valid       = 1'b1;
    in_rd          = rd;
    in_reg_write   = rw;
    in_wb_sel      = sel;
    in_alu_result  = alu;
    in_pc_plus4    = pc4;
    in_load_funct3 = f3;
    in_addr_low    = al;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Accept a load, then return the read word after one wait cycle.
  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] al,
                         input logic [31:0] word, input logic [31:0] exp_data,
                         input logic [31:0] exp_cnt);
    offer(rd, 1'b1, 2'b01, 32'hDEAD_0000, 32'hDEAD_0004, f3, al);
    step();
    in_valid = 1'b0;
    chk("load_ready_low", 32'(in_ready), 32'd0);
    chk("load_wait_en", 32'(reg_write_enable), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    expect_wr(rd, exp_data);
    step();
    mem_rvalid = 1'b0;
    chk("load_en", 32'(reg_write_enable), 32'd1);
    chk("load_cnt", retire_count, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0;
    in_alu_result = '0; in_pc_plus4 = '0; in_load_funct3 = '0; in_addr_low = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; flush = 1'b0;
    #1;
    chk("rst_en", 32'(reg_write_enable), 32'd0);
    chk("rst_addr", 32'(reg_write_addr), 32'd0);
    chk("rst_data", reg_write_data, 32'd0);
    chk("rst_cnt", retire_count, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // ALU op commits the cycle after accept.
    offer(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 3'b000, 2'b00);
    expect_wr(5'd5, 32'h1234);
    step();
    in_valid = 1'b0;
    chk("alu_en", 32'(reg_write_enable), 32'd1);
    chk("alu_cnt", retire_count, 32'd1);
    mem_rvalid = 1'b1;
    flush = 1'b1;
    step();
    mem_rvalid = 1'b0;
    flush = 1'b0;
    chk("idle_en", 32'(reg_write_enable), 32'd0);
    chk("hold_addr", 32'(reg_write_addr), 32'd5);
    chk("hold_data", reg_write_data, 32'h1234);
    step();
    chk("idle_rvalid_ignored", retire_count, 32'd1);

    // LB with an extra wait cycle before the read word.
    offer(5'd7, 1'b1, 2'b01, 32'h0, 32'h0, 3'b000, 2'b10);
    step();
    in_valid = 1'b0;
    chk("lb_ready0", 32'(in_ready), 32'd0);
    step();
    chk("lb_ready1", 32'(in_ready), 32'd0);
    chk("lb_wait_en", 32'(reg_write_enable), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0080_0000;
    expect_wr(5'd7, 32'hFFFF_FF80);
    step();
    mem_rvalid = 1'b0;
    chk("lb_en", 32'(reg_write_enable), 32'd1);
    chk("lb_cnt", retire_count, 32'd2);
    chk("lb_ready_back", 32'(in_ready), 32'd1);
    step();

    load_op(5'd9,  3'b101, 2'b10, 32'hBEEF_0000, 32'h0000_BEEF, 32'd3);
    load_op(5'd10, 3'b001, 2'b11, 32'h8001_1234, 32'hFFFF_8001, 32'd4);
    load_op(5'd11, 3'b010, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'd5);
    load_op(5'd14, 3'b011, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 32'd6);
    load_op(5'd15, 3'b100, 2'b01, 32'h0000_9A00, 32'h0000_009A, 32'd7);
    step();

    // Flush beats a same-edge read response.
    offer(5'd12, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    flush = 1'b0;
    mem_rvalid = 1'b0;
    chk("flush_en", 32'(reg_write_enable), 32'd0);
    chk("flush_cnt", retire_count, 32'd7);
    chk("flush_ready", 32'(in_ready), 32'd1);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("flush_no_late", 32'(reg_write_enable), 32'd0);
    chk("flush_no_late_cnt", retire_count, 32'd7);

    // Non-writing commits still retire; then link value and back-to-back ALU ops.
    offer(5'd0, 1'b1, 2'b10, 32'h0, 32'h100, 3'b000, 2'b00);
    step();
    chk("rd0_en", 32'(reg_write_enable), 32'd0);
    chk("rd0_cnt", retire_count, 32'd8);
    offer(5'd3, 1'b0, 2'b10, 32'h0, 32'h200, 3'b000, 2'b00);
    step();
    chk("rw0_en", 32'(reg_write_enable), 32'd0);
    chk("rw0_cnt", retire_count, 32'd9);
    offer(5'd4, 1'b1, 2'b10, 32'h77, 32'h44, 3'b000, 2'b00);
    expect_wr(5'd4, 32'h44);
    step();
    chk("pc4_en", 32'(reg_write_enable), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      offer(5'(i), 1'b1, (i == 2) ? 2'b11 : 2'b00, 32'hA000 + 32'(i), 32'h0, 3'b000, 2'b00);
      expect_wr(5'(i), 32'hA000 + 32'(i));
      step();
      chk("b2b_en", 32'(reg_write_enable), 32'd1);
      chk("b2b_cnt", retire_count, 32'd10 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end_en", 32'(reg_write_enable), 32'd0);

    // Reset mid-load drops the load; a stray response afterwards is ignored.
    offer(5'd13, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_en", 32'(reg_write_enable), 32'd0);
    chk("mrst_addr", 32'(reg_write_addr), 32'd0);
    chk("mrst_data", reg_write_data, 32'd0);
    chk("mrst_cnt", retire_count, 32'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_en", 32'(reg_write_enable), 32'd0);
    chk("post_rst_cnt", retire_count, 32'd0);
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
